// File: rtl/aes_sched_pkg.sv
// Shared definitions for the masked AES-128 round scheduler.
//   sched_state_e : control FSM state encoding
//   RCON_INIT     : round constant used by round 1
//   RCON_POLY     : AES field reduction constant applied by xtime
//   xtime8()      : multiply-by-x in GF(2^8), the round constant update
package aes_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    function automatic logic [7:0] xtime8(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// AES-128 key schedule round constant register.
// Ports:
//   clk   in   clock
//   rst_n in   synchronous active-low reset, returns rcon to 0x01
//   init  in   reload 0x01 (wins over step)
//   step  in   advance rcon to xtime(rcon)
//   rcon  out  current round constant
module aes_rcon_gen
    import aes_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       step,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (init) begin
            rcon_d = RCON_INIT;
        end else if (step) begin
            rcon_d = xtime8(rcon_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_sched.sv
// Control FSM sequencing the masked AES-128 round datapath.
// One encryption: accept shares (IDLE), load state/key (LOAD, one cycle),
// NROUNDS rounds of SBOX_LAT advancing cycles each (ROUND), then hold the
// result until the consumer takes it (DONE). A cycle without fresh
// randomness freezes the whole round datapath.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid / in_ready input shares handshake
//   rnd_valid / rnd_req fresh randomness available / requested (ROUND)
//   pipe_en             advance the masked S-box pipeline
//   en_load             state := pt ^ key, key := key_in
//   en_state / en_key   commit round output and next round key
//   mix_bypass          last round, skip MixColumns
//   rcon                round constant for the key schedule
//   round               current round index, 0 when idle
//   out_valid/out_ready ciphertext shares handshake
module aes_round_sched
    import aes_sched_pkg::*;
#(
    parameter int NROUNDS  = 10,
    parameter int SBOX_LAT = 4,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          rnd_valid,
    output logic          rnd_req,
    output logic          pipe_en,
    output logic          en_load,
    output logic          en_state,
    output logic          en_key,
    output logic          mix_bypass,
    output logic [7:0]    rcon,
    output logic [CW-1:0] round,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int CYC_W = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(SBOX_LAT - 1);
    localparam logic [CW-1:0]    ROUND_LAST = CW'(NROUNDS);

    sched_state_e   state_q, state_d;
    logic [CW-1:0]  round_q, round_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic in_ready_q, in_ready_d;
    logic en_load_q, en_load_d;
    logic rnd_req_q, rnd_req_d;
    logic mix_bypass_q, mix_bypass_d;
    logic out_valid_q, out_valid_d;

    logic advance;
    logic commit;
    logic rcon_init;
    logic rcon_step;

    // The pipeline only moves in ROUND with fresh randomness; rst_n gates it
    // so that a reset cycle never lets a half-round commit slip through.
    assign advance = rst_n && (state_q == ST_ROUND) && rnd_valid;
    assign commit  = advance && (cyc_q == CYC_LAST);

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        cyc_d     = cyc_q;
        rcon_init = 1'b0;
        rcon_step = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d   = ST_ROUND;
                round_d   = CW'(1);
                cyc_d     = '0;
                rcon_init = 1'b1;
            end
            ST_ROUND: begin
                if (commit) begin
                    cyc_d = '0;
                    if (round_q == ROUND_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        round_d   = round_q + CW'(1);
                        rcon_step = 1'b1;
                    end
                end else if (advance) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d   = ST_IDLE;
                    round_d   = '0;
                    rcon_init = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // in_ready follows the state one cycle late, so the first IDLE cycle
        // after reset or after DONE never accepts; it also drops the cycle
        // after an accept so a held in_valid cannot double-accept.
        in_ready_d   = (state_q == ST_IDLE) && !(in_valid && in_ready_q);
        en_load_d    = (state_d == ST_LOAD);
        rnd_req_d    = (state_d == ST_ROUND);
        mix_bypass_d = (state_d == ST_ROUND) && (round_d == ROUND_LAST);
        out_valid_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            round_q      <= '0;
            cyc_q        <= '0;
            in_ready_q   <= 1'b0;
            en_load_q    <= 1'b0;
            rnd_req_q    <= 1'b0;
            mix_bypass_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            cyc_q        <= cyc_d;
            in_ready_q   <= in_ready_d;
            en_load_q    <= en_load_d;
            rnd_req_q    <= rnd_req_d;
            mix_bypass_q <= mix_bypass_d;
            out_valid_q  <= out_valid_d;
        end
    end

    aes_rcon_gen u_rcon (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (rcon_init),
        .step  (rcon_step),
        .rcon  (rcon)
    );

    assign in_ready   = in_ready_q;
    assign en_load    = en_load_q;
    assign rnd_req    = rnd_req_q;
    assign mix_bypass = mix_bypass_q;
    assign out_valid  = out_valid_q;
    assign round      = round_q;
    assign pipe_en    = advance;
    assign en_state   = commit;
    assign en_key     = commit;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: randomized randomness/backpressure stimulus,
// scoreboard of expected load/commit/done events derived from the per-cycle
// randomness record, plus a SBOX_LAT=1 instance with a fixed timing table.
module tb_aes_round_sched;

    localparam int NR   = 10;
    localparam int L    = 4;
    localparam int NCYC = 8192;

    typedef struct {
        int t;
        int k;
    } cmt_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, rnd_valid, rnd_req, pipe_en;
    logic       en_load, en_state, en_key, mix_bypass, out_valid, out_ready;
    logic [7:0] rcon;
    logic [3:0] round;

    logic       in_valid1, in_ready1, rnd_valid1, rnd_req1, pipe_en1;
    logic       en_load1, en_state1, en_key1, mix_bypass1, out_valid1, out_ready1;
    logic [7:0] rcon1;
    logic [3:0] round1;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    bit  rv [NCYC];
    logic [7:0] rcon_tbl [0:10];

    int   load_q [$];
    cmt_t commit_q [$];
    int   done_q [$];
    bit   dn_active = 0;
    int   acc_count = 0, last_acc = 0;
    int   hs_count = 0, last_hs = 0, last_ov_first = 0;
    bit   or_rand = 0, or_fixed = 1;

    cmt_t f;
    bit   in_round, exp_cmt, exp_ld;

    aes_round_sched #(.NROUNDS(NR), .SBOX_LAT(L), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rnd_valid(rnd_valid), .rnd_req(rnd_req), .pipe_en(pipe_en),
        .en_load(en_load), .en_state(en_state), .en_key(en_key),
        .mix_bypass(mix_bypass), .rcon(rcon), .round(round),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    aes_round_sched #(.NROUNDS(NR), .SBOX_LAT(1), .CW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .rnd_valid(rnd_valid1), .rnd_req(rnd_req1), .pipe_en(pipe_en1),
        .en_load(en_load1), .en_state(en_state1), .en_key(en_key1),
        .mix_bypass(mix_bypass1), .rcon(rcon1), .round(round1),
        .out_valid(out_valid1), .out_ready(out_ready1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > 7500) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 7500", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Cycle in which round k of the encryption accepted at cycle t commits:
    // rounds start two cycles after the accept and each needs L cycles with
    // fresh randomness.
    function automatic int commit_cycle(input int t, input int k);
        int n;
        n = 0;
        for (int c = t + 2; c < NCYC; c++) begin
            if (rv[c]) n++;
            if (n == k * L) return c;
        end
        return -1;
    endfunction

    // Stimulus driver for the free-running inputs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_valid = (cyc < NCYC) ? rv[cyc] : 1'b1;
            out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_fixed;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            dn_active = 0;
        end else begin
            in_round = 0;
            exp_cmt  = 0;
            if (commit_q.size() > 0) begin
                f = commit_q[0];
                in_round = (cyc >= f.t + 2);
                if (in_round) exp_cmt = (cyc == commit_cycle(f.t, f.k));
            end
            check("rnd_req", int'(rnd_req), int'(in_round));
            check("pipe_en", int'(pipe_en), int'(in_round & rnd_valid));
            check("en_state", int'(en_state), int'(exp_cmt));
            check("en_key", int'(en_key), int'(exp_cmt));
            check("mix_bypass", int'(mix_bypass), int'(in_round && (f.k == NR)));
            if (in_round) begin
                check("round", int'(round), f.k);
                check("rcon", int'(rcon), int'(rcon_tbl[f.k]));
            end
            if (exp_cmt) void'(commit_q.pop_front());

            exp_ld = (load_q.size() > 0) && (cyc == load_q[0] + 1);
            check("en_load", int'(en_load), int'(exp_ld));
            if (exp_ld) void'(load_q.pop_front());

            if (!dn_active && done_q.size() > 0 &&
                cyc == commit_cycle(done_q[0], NR) + 1) begin
                dn_active = 1;
                last_ov_first = cyc;
                void'(done_q.pop_front());
            end
            check("out_valid", int'(out_valid), int'(dn_active));
            check("exclusive", int'(en_load) + int'(en_state) + int'(out_valid) <= 1 ? 1 : 0, 1);
            if (in_round || exp_ld || dn_active) check("in_ready_busy", int'(in_ready), 0);

            if (dn_active && out_ready) begin
                dn_active = 0;
                hs_count++;
                last_hs = cyc;
            end
            if (in_valid && in_ready) begin
                load_q.push_back(cyc);
                for (int k = 1; k <= NR; k++) commit_q.push_back('{cyc, k});
                done_q.push_back(cyc);
                acc_count++;
                last_acc = cyc;
            end
        end
    end

    task automatic fill_rv(input bit random_mode, input int len);
        for (int c = cyc + 1; c < cyc + 1 + len && c < NCYC; c++)
            rv[c] = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic wait_acc(input int prev);
        int n;
        n = 0;
        while (acc_count == prev && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", int'(acc_count != prev), 1);
    endtask

    task automatic wait_hs(input int prev);
        int n;
        n = 0;
        while (hs_count == prev && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", int'(hs_count != prev), 1);
    endtask

    task automatic issue(output int t);
        int prev;
        prev = acc_count;
        @(posedge clk);
        #1 in_valid = 1'b1;
        wait_acc(prev);
        t = last_acc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        int t, hs0, acc0, h, n, t1;
        rcon_tbl = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int c = 0; c < NCYC; c++) rv[c] = 1'b1;
        rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b1; out_ready = 1'b1;
        in_valid1 = 1'b0; rnd_valid1 = 1'b1; out_ready1 = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_round", int'(round), 0);
        check("rst_rcon", int'(rcon), 8'h01);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_en_load", int'(en_load), 0);
        check("rst_rnd_req", int'(rnd_req), 0);
        check("rst_mix_bypass", int'(mix_bypass), 0);
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);

        // Nominal encryption.
        fill_rv(0, 300);
        hs0 = hs_count;
        issue(t);
        wait_hs(hs0);
        check("nominal_latency", last_ov_first - t, 2 + NR * L);

        // Three stalled cycles inside round 4.
        fill_rv(0, 300);
        hs0 = hs_count;
        issue(t);
        for (int c = t + 15; c <= t + 17; c++) rv[c] = 1'b0;
        wait_hs(hs0);
        check("stall_latency", last_ov_first - t, 2 + NR * L + 3);

        // Output backpressure, then back-to-back accept with in_valid held.
        fill_rv(0, 400);
        or_fixed = 1'b0;
        hs0 = hs_count;
        issue(t);
        n = 0;
        while (!dn_active && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_done_seen", int'(dn_active), 1);
        @(posedge clk);
        #1 in_valid = 1'b1;
        acc0 = acc_count;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid_held", int'(out_valid), 1);
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        check("bp_no_accept", acc_count, acc0);
        @(posedge clk);
        #1 or_fixed = 1'b1;
        wait_hs(hs0);
        h = last_hs;
        wait_acc(acc0);
        check("b2b_accept_gap", last_acc - h, 2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_hs(hs0 + 1);

        // Random randomness availability and random consumer readiness.
        or_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fill_rv(1, 400);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            hs0 = hs_count;
            issue(t);
            wait_hs(hs0);
        end
        or_rand = 1'b0;
        or_fixed = 1'b1;

        // Reset while round 6 is in progress.
        fill_rv(0, 400);
        issue(t);
        n = 0;
        while (cyc < t + 2 + 5 * L + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_round6", int'(round), 6);
        @(posedge clk);
        #1 rst_n = 1'b0;
        load_q.delete();
        commit_q.delete();
        done_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_round", int'(round), 0);
        check("abort_rcon", int'(rcon), 8'h01);
        check("abort_en_state", int'(en_state), 0);
        check("abort_en_key", int'(en_key), 0);
        check("abort_pipe_en", int'(pipe_en), 0);
        check("abort_en_load", int'(en_load), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_rnd_req", int'(rnd_req), 0);
        repeat (50) @(negedge clk);
        fill_rv(0, 300);
        hs0 = hs_count;
        issue(t);
        wait_hs(hs0);
        check("post_abort_latency", last_ov_first - t, 2 + NR * L);

        // SBOX_LAT = 1 instance: commit every cycle.
        @(posedge clk);
        #1 in_valid1 = 1'b1;
        n = 0;
        t1 = -1;
        while (t1 < 0 && n < 50) begin
            @(negedge clk);
            if (in_valid1 && in_ready1) t1 = cyc;
            n++;
        end
        check("lat1_accept", int'(t1 >= 0), 1);
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        for (int d = 1; d <= 13; d++) begin
            @(negedge clk);
            check("lat1_en_load", int'(en_load1), int'(d == 1));
            check("lat1_en_state", int'(en_state1), int'(d >= 2 && d <= 11));
            check("lat1_en_key", int'(en_key1), int'(d >= 2 && d <= 11));
            check("lat1_out_valid", int'(out_valid1), int'(d == 12));
            check("lat1_mix_bypass", int'(mix_bypass1), int'(d == 11));
            if (d >= 2 && d <= 11) begin
                check("lat1_round", int'(round1), d - 1);
                check("lat1_rcon", int'(rcon1), int'(rcon_tbl[d - 1]));
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", load_q.size() + commit_q.size() + done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
